// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encodings,
// the scoreboard entry layout and the select-width derivation.
package pipe_hazard_pkg;

    // Entries are sized for the widest legal configuration; narrower
    // instances zero-extend register numbers into these fields.
    localparam int MAX_REG_AW = 8;
    localparam int MAX_SRC    = 3;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                                valid;
        logic [MAX_REG_AW-1:0]               dest;
        logic                                wb_en;
        logic                                mem_r_en;
        logic [MAX_SRC-1:0][MAX_REG_AW-1:0]  src;
        logic [MAX_SRC-1:0]                  src_used;
    } sb_entry_t;

    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_src_select.sv
// Priority match of one EXE source register against the tracked stages
// after EXE; the nearest stage with a pending write wins.
module fwd_src_select
    import pipe_hazard_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = 2
) (
    input  logic                                en,
    input  logic [MAX_REG_AW-1:0]               src,
    input  logic [FWD_DEPTH-1:0]                wr_en,
    input  logic [FWD_DEPTH-1:0][MAX_REG_AW-1:0] wr_dest,
    output logic [SEL_W-1:0]                    sel
);

    // Scan far-to-near so the nearest matching stage is the last one written.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (en) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (wr_en[k] && (wr_dest[k] == src)) begin
                    sel = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of EXE and later stages, stall,
// flush, memory-wait hold and operand forwarding selects.
// Optional perf counters (stall_cnt, flush_cnt) under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = fwd_sel_width(FWD_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_r_en,
    input  logic                       branch_taken,
    input  logic                       mem_ready,
    input  logic                       fwd_en,
    output logic                       freeze,
    output logic                       bubble,
    output logic                       flush,
    output logic                       hold_all,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
`endif
);

    sb_entry_t [FWD_DEPTH:0] sb_q, sb_d;
    sb_entry_t               id_entry;
    logic                    hit_exe, hit_near, raw_stall;
    logic                    sb_unused;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.dest     = MAX_REG_AW'(id_dest);
        id_entry.wb_en    = id_wb_en;
        id_entry.mem_r_en = id_mem_r_en;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_entry.src[i]      = MAX_REG_AW'(id_src[i*REG_AW +: REG_AW]);
            id_entry.src_used[i] = id_src_used[i];
        end
    end

    // The last stage writes the register file this cycle, so only
    // entries 0..FWD_DEPTH-1 can block ID when forwarding is off.
    always_comb begin
        hit_exe  = 1'b0;
        hit_near = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (id_src_used[i] && sb_q[k].valid && sb_q[k].wb_en &&
                    (sb_q[k].dest == id_entry.src[i])) begin
                    hit_near = 1'b1;
                    if (k == 0) begin
                        hit_exe = 1'b1;
                    end
                end
            end
        end
    end

    assign raw_stall = fwd_en ? (hit_exe & sb_q[0].mem_r_en) : hit_near;
    assign flush     = rst & branch_taken & mem_ready;
    assign hold_all  = rst & ~mem_ready;
    assign freeze    = rst & mem_ready & ~branch_taken & id_valid & raw_stall;
    assign bubble    = freeze;

    always_comb begin
        sb_d = sb_q;
        if (mem_ready) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = (id_valid && !freeze && !flush) ? id_entry : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    logic [FWD_DEPTH-1:0]                  wr_en;
    logic [FWD_DEPTH-1:0][MAX_REG_AW-1:0]  wr_dest;

    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            wr_en[k]   = sb_q[k+1].valid & sb_q[k+1].wb_en;
            wr_dest[k] = sb_q[k+1].dest;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_select #(
            .FWD_DEPTH (FWD_DEPTH),
            .SEL_W     (SEL_W)
        ) u_fwd_src_select (
            .en      (fwd_en & sb_q[0].valid & sb_q[0].src_used[g]),
            .src     (sb_q[0].src[g]),
            .wr_en   (wr_en),
            .wr_dest (wr_dest),
            .sel     (fwd_sel[g*SEL_W +: SEL_W])
        );
    end

    // The oldest entry only needs its write fields; the rest retire here.
    assign sb_unused = ^{sb_q[FWD_DEPTH].mem_r_en, sb_q[FWD_DEPTH].src,
                         sb_q[FWD_DEPTH].src_used};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default parameters: 4-bit registers,
// two sources, stages EXE/MEM/WB). Inputs change on the falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [7:0] id_src = '0;
    logic [1:0] id_src_used = '0;
    logic [3:0] id_dest = '0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_r_en = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b1;
    logic       fwd_en = 1'b1;
    logic       freeze, bubble, flush, hold_all;
    logic [3:0] fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .fwd_en       (fwd_en),
        .freeze       (freeze),
        .bubble       (bubble),
        .flush        (flush),
        .hold_all     (hold_all),
        .fwd_sel      (fwd_sel)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic set_id(input logic [3:0] dest, input logic wb, input logic memr,
                          input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used);
        id_valid    = 1'b1;
        id_dest     = dest;
        id_wb_en    = wb;
        id_mem_r_en = memr;
        id_src      = {s1, s0};
        id_src_used = used;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_src_used = '0;
        id_wb_en    = 1'b0;
        id_mem_r_en = 1'b0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        branch_taken = 1'b1;
        set_id(4'd1, 1'b1, 1'b1, 4'd1, 4'd1, 2'b11);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %b exp 0", freeze); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got %b exp 0", bubble); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_fwd_sel got %b exp 0000", fwd_sel); end
        mem_ready = 1'b0;
        #1;
        checks++; if (hold_all !== 1'b0) begin errors++; $display("FAIL rst_hold_all got %b exp 0", hold_all); end
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        idle();
        tick();
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_alu_fwd();
        set_id(4'd1, 1'b1, 1'b0, 4'd2, 4'd3, 2'b11);
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL alu_add_freeze got %b exp 0", freeze); end
        tick();
        set_id(4'd2, 1'b1, 1'b0, 4'd1, 4'd4, 2'b11);
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL alu_sub_freeze got %b exp 0", freeze); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL alu_sub_bubble got %b exp 0", bubble); end
        tick();
        idle();
        #1;
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL alu_fwd_sel got %b exp 0001", fwd_sel); end
        fwd_en = 1'b0;
        #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL alu_fwd_off got %b exp 0000", fwd_sel); end
        fwd_en = 1'b1;
        tick();
        #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL alu_exe_empty got %b exp 0000", fwd_sel); end
        tick(3);
    endtask

    task automatic test_load_use();
        set_id(4'd3, 1'b1, 1'b1, 4'd5, 4'd0, 2'b01);
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL ld_issue_freeze got %b exp 0", freeze); end
        tick();
        set_id(4'd4, 1'b1, 1'b0, 4'd3, 4'd6, 2'b11);
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL ld_use_freeze got %b exp 1", freeze); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL ld_use_bubble got %b exp 1", bubble); end
        tick();
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL ld_stall_end_freeze got %b exp 0", freeze); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL ld_stall_end_bubble got %b exp 0", bubble); end
        tick();
        idle();
        #1;
        // The bubble sits in MEM, so the load is forwarded from WB.
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL ld_fwd_sel got %b exp 0010", fwd_sel); end
        tick(3);
    endtask

    task automatic test_nearest();
        set_id(4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd5, 1'b1, 1'b0, 4'd7, 4'd0, 2'b01);
        tick();
        set_id(4'd8, 1'b1, 1'b0, 4'd5, 4'd5, 2'b11);
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL near_freeze got %b exp 0", freeze); end
        tick();
        idle();
        #1;
        checks++; if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL near_fwd_sel got %b exp 0101", fwd_sel); end
        tick(3);

        fwd_en = 1'b0;
        set_id(4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd5, 1'b1, 1'b0, 4'd7, 4'd0, 2'b01);
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL nofwd_indep_freeze got %b exp 0", freeze); end
        tick();
        set_id(4'd8, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01);
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL nofwd_exe_freeze got %b exp 1", freeze); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL nofwd_exe_bubble got %b exp 1", bubble); end
        tick();
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL nofwd_mem_freeze got %b exp 1", freeze); end
        tick();
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL nofwd_wb_freeze got %b exp 0", freeze); end
        tick();
        idle();
        tick(3);
        fwd_en = 1'b1;
    endtask

    task automatic test_branch();
        set_id(4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
        branch_taken = 1'b1;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", flush); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL br_freeze got %b exp 0", freeze); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL br_bubble got %b exp 0", bubble); end
        tick();
        branch_taken = 1'b0;
        fwd_en = 1'b0;
        set_id(4'd9, 1'b1, 1'b0, 4'd4, 4'd0, 2'b01);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_clear got %b exp 0", flush); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL br_squashed_freeze got %b exp 0", freeze); end
        set_id(4'd9, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL br_load_kept_freeze got %b exp 1", freeze); end
        idle();
        tick(3);
        fwd_en = 1'b1;
    endtask

    task automatic test_mem_wait();
        set_id(4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd2, 1'b1, 1'b1, 4'd1, 4'd0, 2'b01);
        tick();
        set_id(4'd6, 1'b1, 1'b0, 4'd2, 4'd0, 2'b01);
        mem_ready = 1'b0;
        branch_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (hold_all !== 1'b1) begin errors++; $display("FAIL wait_hold_all cyc %0d got %b exp 1", c, hold_all); end
            checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL wait_fwd_sel cyc %0d got %b exp 0001", c, fwd_sel); end
            checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL wait_bubble cyc %0d got %b exp 0", c, bubble); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL wait_flush cyc %0d got %b exp 0", c, flush); end
            tick();
        end
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        #1;
        checks++; if (hold_all !== 1'b0) begin errors++; $display("FAIL wait_release_hold got %b exp 0", hold_all); end
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL wait_release_fwd got %b exp 0001", fwd_sel); end
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL wait_release_ld_use got %b exp 1", freeze); end
        tick();
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL wait_stall_end got %b exp 0", freeze); end
        tick();
        idle();
        #1;
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL wait_after_fwd got %b exp 0010", fwd_sel); end
        tick(3);
    endtask

    task automatic test_reset_mid_stall();
        fwd_en = 1'b0;
        set_id(4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd8, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01);
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL mid_pre_freeze got %b exp 1", freeze); end
        rst = 1'b0;
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL mid_rst_freeze got %b exp 0", freeze); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL mid_rst_bubble got %b exp 0", bubble); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_rst_flush got %b exp 0", flush); end
        checks++; if (hold_all !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got %b exp 0", hold_all); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL mid_rst_fwd_sel got %b exp 0000", fwd_sel); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        tick();
        rst = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL mid_release_freeze got %b exp 0", freeze); end
        tick();
        idle();
        tick(3);
        fwd_en = 1'b1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        set_id(4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);
        tick();
        set_id(4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
        tick();
        #1;
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL perf_stall_cnt got %0d exp 1", stall_cnt); end
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        idle();
        #1;
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL perf_flush_cnt got %0d exp 1", flush_cnt); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL perf_stall_hold got %0d exp 1", stall_cnt); end
        tick(3);
    endtask
`endif

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_nearest();
        test_branch();
        test_mem_wait();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
